// File: rtl/optimsoc_tile_bus_decoder.sv
// Wishbone B3 decoder from the tile CPU master to DM, PGAS, network adapter and boot ROM.
// The slave select is registered once per cycle and held until the master drops cyc.
module optimsoc_tile_bus_decoder #(
  parameter int          DM_RANGE_WIDTH   = 1,
  parameter logic [31:0] DM_RANGE_MATCH   = 32'h0,
  parameter int          ENABLE_PGAS      = 0,
  parameter int          PGAS_RANGE_WIDTH = 4,
  parameter logic [31:0] PGAS_RANGE_MATCH = 32'h8,
  parameter int          ENABLE_BOOTROM   = 1,
  parameter int          TIMEOUT_CYCLES   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m_adr_i,
  input  logic [31:0]  m_dat_i,
  input  logic [3:0]   m_sel_i,
  input  logic         m_we_i,
  input  logic         m_cyc_i,
  input  logic         m_stb_i,
  input  logic [2:0]   m_cti_i,
  input  logic [1:0]   m_bte_i,
  output logic [31:0]  m_dat_o,
  output logic         m_ack_o,
  output logic         m_err_o,
  output logic         m_rty_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  output logic [3:0]   s_sel_o,
  output logic         s_we_o,
  output logic [2:0]   s_cti_o,
  output logic [1:0]   s_bte_o,
  output logic [3:0]   s_cyc_o,
  output logic [3:0]   s_stb_o,
  input  logic [127:0] s_dat_i,
  input  logic [3:0]   s_ack_i,
  input  logic [3:0]   s_err_i,
  input  logic [3:0]   s_rty_i,
  output logic         bus_err_o,
  output logic [31:0]  err_adr_o,
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FWD   = 2'd1;
  localparam logic [1:0] DERR  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [1:0] SEL_DM   = 2'd0;
  localparam logic [1:0] SEL_PGAS = 2'd1;
  localparam logic [1:0] SEL_NA   = 2'd2;
  localparam logic [1:0] SEL_ROM  = 2'd3;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [1:0]  sel;
  logic [15:0] to_cnt;

  logic        dec_hit;
  logic [1:0]  dec_sel;
  logic        dm_match;
  logic        pgas_match;
  logic        resp;
  logic        expire;
  logic        fwd;

  assign state_dbg = state;

  // Broadcast fields go to every slave; only cyc/stb qualify the transfer.
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
  assign s_cti_o = m_cti_i;
  assign s_bte_o = m_bte_i;

  assign dm_match   = (m_adr_i >> (32 - DM_RANGE_WIDTH)) == DM_RANGE_MATCH;
  assign pgas_match = (m_adr_i >> (32 - PGAS_RANGE_WIDTH)) == PGAS_RANGE_MATCH;

  always_comb begin
    dec_hit = 1'b1;
    dec_sel = SEL_DM;
    if (m_adr_i[31:28] == 4'hE) begin
      dec_sel = SEL_NA;
    end else if ((ENABLE_BOOTROM != 0) && (m_adr_i[31:28] == 4'hF)) begin
      dec_sel = SEL_ROM;
    end else if (dm_match) begin
      dec_sel = SEL_DM;
    end else if ((ENABLE_PGAS != 0) && pgas_match) begin
      dec_sel = SEL_PGAS;
    end else begin
      dec_hit = 1'b0;
    end
  end

  // A slave response in the expiry cycle wins over the timeout.
  assign resp   = s_ack_i[sel] | s_err_i[sel] | s_rty_i[sel];
  assign expire = (state == FWD) && m_cyc_i && m_stb_i && !resp &&
                  (to_cnt >= TIMEOUT_LIMIT);
  assign fwd    = (state == FWD) && !expire;

  always_comb begin
    s_cyc_o   = 4'b0000;
    s_stb_o   = 4'b0000;
    m_dat_o   = 32'h0;
    m_ack_o   = 1'b0;
    m_rty_o   = 1'b0;
    m_err_o   = expire || (state == DERR);
    bus_err_o = expire || (state == DERR);
    if (fwd) begin
      s_cyc_o[sel] = m_cyc_i;
      s_stb_o[sel] = m_stb_i;
      m_dat_o      = s_dat_i[sel*32 +: 32];
      m_ack_o      = m_cyc_i & s_ack_i[sel];
      m_rty_o      = m_cyc_i & s_rty_i[sel];
      m_err_o      = m_cyc_i & s_err_i[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= SEL_DM;
      to_cnt    <= 16'h0;
      err_adr_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if (dec_hit) begin
              state  <= FWD;
              sel    <= dec_sel;
              to_cnt <= 16'h0;
            end else begin
              state <= DERR;
            end
          end
        end
        FWD: begin
          if (!m_cyc_i) begin
            state <= IDLE;
          end else if (expire) begin
            state     <= DRAIN;
            err_adr_o <= m_adr_i;
          end else if (resp) begin
            to_cnt <= 16'h0;
          end else if (m_stb_i) begin
            to_cnt <= to_cnt + 16'h1;
          end
        end
        DERR: begin
          err_adr_o <= m_adr_i;
          state     <= DRAIN;
        end
        default: begin
          // DRAIN: swallow whatever the master or a late slave does until cyc drops.
          if (!m_cyc_i) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_optimsoc_tile_bus_decoder.sv
// Directed bench for the tile bus decoder: read data flows through an expected queue,
// control outputs are checked cycle by cycle against hand-derived values.
module tb_optimsoc_tile_bus_decoder;

  logic         clk;
  logic         rst;
  logic [31:0]  m_adr_i, m_dat_i;
  logic [3:0]   m_sel_i;
  logic         m_we_i, m_cyc_i, m_stb_i;
  logic [2:0]   m_cti_i;
  logic [1:0]   m_bte_i;
  logic [31:0]  m_dat_o;
  logic         m_ack_o, m_err_o, m_rty_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic [2:0]   s_cti_o;
  logic [1:0]   s_bte_o;
  logic [3:0]   s_cyc_o, s_stb_o;
  logic [127:0] s_dat_i;
  logic [3:0]   s_ack_i, s_err_i, s_rty_i;
  logic         bus_err_o;
  logic [31:0]  err_adr_o;
  logic [1:0]   state_dbg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FWD   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  optimsoc_tile_bus_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .bus_err_o(bus_err_o), .err_adr_o(err_adr_o), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after posedge, outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_master();
    m_adr_i = 32'h0; m_dat_i = 32'h0; m_sel_i = 4'h0; m_we_i = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_cti_i = 3'b000; m_bte_i = 2'b00;
  endtask

  task automatic clear_slaves();
    s_ack_i = 4'h0; s_err_i = 4'h0; s_rty_i = 4'h0;
  endtask

  task automatic start(input logic [31:0] adr, input logic we, input logic [2:0] cti);
    m_adr_i = adr; m_we_i = we; m_cti_i = cti; m_sel_i = 4'hF; m_bte_i = 2'b00;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
  endtask

  task automatic slave_ack(input int n, input logic [31:0] dat);
    s_ack_i[n] = 1'b1;
    s_dat_i[n*32 +: 32] = dat;
    exp_q.push_back(dat);
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_ack_beat(input string tag);
    chk({tag, "_ack"}, 32'(m_ack_o), 32'h1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_underflow"}, 32'(exp_q.size()), 32'h1);
    end else begin
      chk({tag, "_dat"}, m_dat_o, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    s_dat_i = '0;
    idle_master();
    clear_slaves();
    tick();
    tick();
    settle();
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_m_ack_err", 32'({m_ack_o, m_err_o, m_rty_o, bus_err_o}), 32'h0);
    chk("rst_err_adr", err_adr_o, 32'h0);
    tick();
    rst = 1'b0;

    // classic read to DM, ack on the third forwarded cycle
    tick();
    start(32'h0000_0100, 1'b0, 3'b000);
    settle();
    chk("rd_c0_s_stb", 32'(s_stb_o), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) slave_ack(0, 32'hCAFE_F00D);
      settle();
      chk("rd_s_stb", 32'(s_stb_o), 32'h1);
      chk("rd_s_cyc", 32'(s_cyc_o), 32'h1);
      chk("rd_err", 32'(m_err_o), 32'h0);
      if (c == 3) check_ack_beat("rd");
      else chk("rd_early_ack", 32'(m_ack_o), 32'h0);
    end
    tick();
    idle_master();
    clear_slaves();
    settle();
    chk("rd_end_s_cyc", 32'(s_cyc_o), 32'h0);

    // 4-beat incrementing burst to the network adapter
    tick();
    start(32'hE000_0000, 1'b0, 3'b010);
    settle();
    chk("na_c0_s_cyc", 32'(s_cyc_o), 32'h0);
    for (int b = 0; b < 4; b++) begin
      tick();
      m_adr_i = 32'hE000_0000 + 32'(4 * b);
      m_cti_i = (b == 3) ? 3'b111 : 3'b010;
      slave_ack(2, 32'h1000_0000 + 32'(b));
      settle();
      chk("na_s_cyc", 32'(s_cyc_o), 32'h4);
      check_ack_beat("na");
    end
    tick();
    idle_master();
    clear_slaves();
    settle();
    chk("na_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    tick();
    settle();
    chk("na_idle", 32'(state_dbg), 32'(ST_IDLE));

    // unmapped PGAS address: decode error
    tick();
    start(32'h8000_0000, 1'b0, 3'b000);
    settle();
    chk("derr_c0_err", 32'(m_err_o), 32'h0);
    tick();
    settle();
    chk("derr_c1_err", 32'(m_err_o), 32'h1);
    chk("derr_c1_bus_err", 32'(bus_err_o), 32'h1);
    chk("derr_c1_s_stb", 32'(s_stb_o), 32'h0);
    tick();
    settle();
    chk("derr_c2_err", 32'({m_err_o, bus_err_o}), 32'h0);
    chk("derr_err_adr", err_adr_o, 32'h8000_0000);
    chk("derr_c2_s_stb", 32'(s_stb_o), 32'h0);
    tick();
    idle_master();
    tick();
    settle();
    chk("derr_idle", 32'(state_dbg), 32'(ST_IDLE));

    // boot ROM write with no response: timeout after 8 waiting cycles
    tick();
    start(32'hF000_0004, 1'b1, 3'b000);
    m_dat_i = 32'h1234_5678;
    settle();
    for (int c = 1; c <= 8; c++) begin
      tick();
      settle();
      chk("to_wait_err", 32'(m_err_o), 32'h0);
      if (c == 1) begin
        chk("to_s_cyc", 32'(s_cyc_o), 32'h8);
        chk("to_s_dat", s_dat_o, 32'h1234_5678);
        chk("to_s_we", 32'(s_we_o), 32'h1);
      end
    end
    tick();
    settle();
    chk("to_c9_err", 32'(m_err_o), 32'h1);
    chk("to_c9_bus_err", 32'(bus_err_o), 32'h1);
    chk("to_c9_s_cyc", 32'(s_cyc_o), 32'h0);
    tick();
    s_ack_i[3] = 1'b1;
    settle();
    chk("to_late_ack", 32'(m_ack_o), 32'h0);
    chk("to_drain_err", 32'(m_err_o), 32'h0);
    chk("to_drain_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("to_err_adr", err_adr_o, 32'hF000_0004);
    chk("to_drain_state", 32'(state_dbg), 32'(ST_DRAIN));
    tick();
    idle_master();
    clear_slaves();
    tick();
    settle();
    chk("to_idle", 32'(state_dbg), 32'(ST_IDLE));

    // ack arriving exactly at expiry wins over the timeout
    tick();
    start(32'hF000_0000, 1'b0, 3'b000);
    for (int c = 1; c <= 8; c++) tick();
    tick();
    slave_ack(3, 32'h0B00_7ED0);
    settle();
    chk("race_err", 32'(m_err_o), 32'h0);
    chk("race_bus_err", 32'(bus_err_o), 32'h0);
    check_ack_beat("race");
    chk("race_state", 32'(state_dbg), 32'(ST_FWD));
    tick();
    idle_master();
    clear_slaves();
    tick();
    settle();
    chk("race_err_adr_hold", err_adr_o, 32'hF000_0004);

    // DM burst aborted after beat 2, then a fresh access decodes to the NA
    tick();
    start(32'h0000_0200, 1'b0, 3'b010);
    for (int b = 0; b < 2; b++) begin
      tick();
      m_adr_i = 32'h0000_0200 + 32'(4 * b);
      slave_ack(0, 32'h2000_0000 + 32'(b));
      settle();
      check_ack_beat("abort");
    end
    tick();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    clear_slaves();
    settle();
    chk("abort_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("abort_ack", 32'(m_ack_o), 32'h0);
    tick();
    start(32'hE000_0000, 1'b0, 3'b000);
    settle();
    chk("redec_c0_s_stb", 32'(s_stb_o), 32'h0);
    tick();
    slave_ack(2, 32'h5A5A_0002);
    settle();
    chk("redec_s_stb", 32'(s_stb_o), 32'h4);
    check_ack_beat("redec");
    tick();
    idle_master();
    clear_slaves();

    // reset while a beat is pending
    tick();
    start(32'h0000_0100, 1'b0, 3'b000);
    tick();
    settle();
    chk("mid_rst_s_stb", 32'(s_stb_o), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_master();
    settle();
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mid_rst_s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("mid_rst_m_out", 32'({m_ack_o, m_err_o, m_rty_o, bus_err_o}), 32'h0);
    chk("mid_rst_m_dat", m_dat_o, 32'h0);
    chk("mid_rst_err_adr", err_adr_o, 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
